keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
Scans the 4x4 PmodKYPD matrix and debounces presses. Emits one clean event per physical key press: a 1-cycle key_valid strobe with a stable 4-bit key_code.
Sits directly upstream of the smart-lock password logic, which shifts key_code in on key_valid instead of detecting value changes.
Handles the full keypad electrical interface. Column drive and row sensing are both active-low.

Parameters:
SCAN_DIV, 1000, clocks each column is driven before its rows are sampled; must be >= 4
DEBOUNCE_CNT, 50000, consecutive identical synced samples required to accept a press or a release; must be >= 2
REPEAT_DELAY, 50000000, clocks held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_PERIOD, 10000000, clocks between subsequent auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
col_out  output  4  column drive, one-hot low (to JA[3:0])
row_in  input  4  row sense, low = pressed (from JA[7:4]), asynchronous
key_code  output  4  code of last accepted key, held until next press
key_valid  output  1  1-cycle strobe, key_code valid this cycle
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset (async, rst_n=0) and all state: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=SCAN, all counters 0. Reset mid-press: all of this applies immediately; the press is not reported after reset release unless it is re-debounced from SCAN.
- row_in passes through a 2-FF synchronizer. All decisions use the synced value rs.
- Key map, as (column index, row index) -> code:
  - col0: rows 0..3 -> 1, 4, 7, 0
  - col1: rows 0..3 -> 2, 5, 8, F
  - col2: rows 0..3 -> 3, 6, 9, E
  - col3: rows 0..3 -> A, B, C, D
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - scan_cnt counts 0..SCAN_DIV-1 with the current column driven low.
  - At scan_cnt==SCAN_DIV-1, rs is sampled.
  - Exactly one row low: capture the column, row and pattern, enter DEBOUNCE, keep the same column driven, and set db_cnt=1.
  - All rows high, or more than one row low (ghosting/ambiguous): advance the column 0->1->2->3->0 and restart scan_cnt.
- DEBOUNCE:
  - Every cycle, compare rs to the captured pattern.
  - Match: db_cnt++.
  - Mismatch: return to SCAN, advance the column, no event.
  - Match that makes db_cnt==DEBOUNCE_CNT: next cycle key_code<=mapped code, key_valid=1 for exactly one cycle, key_held<=1, FSM=HELD.
- HELD:
  - Column stays driven.
  - rs==4'b1111 enters RELEASE with rel_cnt=1.
  - Anything else keeps HELD; other keys pressed meanwhile are ignored.
- RELEASE:
  - rs==4'b1111: rel_cnt++. When rel_cnt reaches DEBOUNCE_CNT: key_held<=0, advance the column, go to SCAN.
  - Any row low: back to HELD, no new event (bounce on release).
- key_code changes only when key_valid strobes. key_valid never asserts on two consecutive cycles (the repeat feature cannot violate this either).
- Latency from the first stable synced sample of a press to key_valid is DEBOUNCE_CNT cycles, plus up to 4*SCAN_DIV scan delay, plus 2 synchronizer cycles.
- Counters saturate/reset as stated; no wrap in HELD.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in HELD, a hold counter starts at entry.
  - When it reaches REPEAT_DELAY, key_valid pulses again with the same key_code.
  - Further pulses follow every REPEAT_PERIOD clocks while still HELD.
  - Entering RELEASE clears the counter. Returning to HELD from RELEASE (bounce) continues the count without resetting it.
- Not defined: exactly one key_valid per press; no hold counter logic is synthesized.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DELAY=40, REPEAT_PERIOD=20.
- Reset: rst_n=0 mid-scan -> col_out=1110, key_code=0, key_valid=0, key_held=0 immediately (before the next clk edge).
- Clean press of key 5: model pulls row1 low while col_out=1101 -> exactly one key_valid pulse with key_code=5, key_held=1; release -> key_held=0 after 8 high samples, no second pulse.
- Bounce: row toggles every 3 cycles for 30 cycles, then stable low on col3/row2 -> no pulse during bounce, then a single pulse with key_code=C.
- Sequence 1,2,3,4 with full releases -> four pulses in order with codes 1,2,3,4 (downstream lock sees 16'h1234).
- Two rows low in one column (keys 3 and 6) -> no key_valid; scanning continues through all four columns.
- Auto-repeat:
  - With KEYPAD_REPEAT_EN, hold D for 100 cycles -> pulses at accept, +40, +60, +80, +100 (while HELD).
  - Without the macro -> single pulse.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad matrix scanner with press/release debounce.
// Drives one column low at a time, samples the synchronized rows, and emits a
// one-cycle key_valid strobe with a stable key_code for each accepted press.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DIV      = 1000,
    parameter int unsigned DEBOUNCE_CNT  = 50000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_out,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);

    // Elaboration-time parameter sanity
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scan_debounce: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_CNT < 2) begin : g_bad_debounce_cnt
        $error("keypad_scan_debounce: DEBOUNCE_CNT must be >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("keypad_scan_debounce: repeat intervals must be >= 2 so strobes never abut");
    end

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        row_meta_q;
    logic [3:0]        rs_q;
    logic [1:0]        col_idx_q;
    logic [1:0]        row_idx_q;
    logic [3:0]        col_out_q;
    logic [3:0]        pat_q;
    logic [3:0]        key_code_q;
    logic              key_valid_q;
    logic              key_held_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   rel_cnt_q;

    logic [3:0]        rs_low_c;
    logic              one_low_c;
    logic [1:0]        row_sel_c;
    logic [1:0]        col_next_c;
    logic [3:0]        col_next_drive_c;
    logic              rep_fire_c;

    // Key legend for (column, row)
    function automatic logic [3:0] map_key(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        code = 4'h0;
        case ({col, row})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Exactly-one-row-low detection; more than one low row is treated as ghosting
    assign rs_low_c         = ~rs_q;
    assign one_low_c        = (rs_low_c != 4'd0) && ((rs_low_c & (rs_low_c - 4'd1)) == 4'd0);
    assign col_next_c       = col_idx_q + 2'd1;
    assign col_next_drive_c = 4'(~(4'b0001 << col_next_c));

    // Index of the low row (only meaningful when one_low_c)
    always_comb begin
        row_sel_c = 2'd0;
        if (!rs_q[0])      row_sel_c = 2'd0;
        else if (!rs_q[1]) row_sel_c = 2'd1;
        else if (!rs_q[2]) row_sel_c = 2'd2;
        else if (!rs_q[3]) row_sel_c = 2'd3;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              rep_phase_q;

    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD
    assign rep_fire_c = (state_q == ST_HELD) &&
                        (hold_cnt_q == (rep_phase_q ? HOLD_W'(REPEAT_PERIOD - 1)
                                                    : HOLD_W'(REPEAT_DELAY - 1)));

    // Hold timer: armed while debouncing, cleared on entering release, frozen in release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
        end else if (state_q == ST_DEBOUNCE) begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
        end else if (state_q == ST_HELD) begin
            if (rep_fire_c) begin
                hold_cnt_q  <= '0;
                rep_phase_q <= 1'b1;
            end else if (rs_q == 4'hF) begin
                hold_cnt_q  <= '0;
            end else begin
                hold_cnt_q  <= hold_cnt_q + HOLD_W'(1);
            end
        end
    end
`else
    assign rep_fire_c = 1'b0;
`endif

    // Row synchronizer, scan/debounce FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            row_meta_q  <= 4'hF;
            rs_q        <= 4'hF;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            pat_q       <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            scan_cnt_q  <= '0;
            db_cnt_q    <= '0;
            rel_cnt_q   <= '0;
        end else begin
            row_meta_q  <= row_in;
            rs_q        <= row_meta_q;
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                        scan_cnt_q <= '0;
                        if (one_low_c) begin
                            state_q   <= ST_DEBOUNCE;
                            pat_q     <= rs_q;
                            row_idx_q <= row_sel_c;
                            db_cnt_q  <= DB_W'(1);
                        end else begin
                            col_idx_q <= col_next_c;
                            col_out_q <= col_next_drive_c;
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs_q == pat_q) begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                        if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                            key_code_q  <= map_key(col_idx_q, row_idx_q);
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            state_q     <= ST_HELD;
                        end
                    end else begin
                        state_q   <= ST_SCAN;
                        db_cnt_q  <= '0;
                        col_idx_q <= col_next_c;
                        col_out_q <= col_next_drive_c;
                    end
                end
                ST_HELD: begin
                    key_valid_q <= rep_fire_c;
                    if (rs_q == 4'hF) begin
                        state_q   <= ST_RELEASE;
                        rel_cnt_q <= DB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (rs_q == 4'hF) begin
                        if (rel_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                            key_held_q <= 1'b0;
                            rel_cnt_q  <= '0;
                            state_q    <= ST_SCAN;
                            col_idx_q  <= col_next_c;
                            col_out_q  <= col_next_drive_c;
                        end else begin
                            rel_cnt_q <= rel_cnt_q + DB_W'(1);
                        end
                    end else begin
                        state_q <= ST_HELD;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce: behavioural keypad matrix plus a
// scoreboard of expected key codes consumed on every key_valid strobe.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;

    localparam int unsigned SCAN_DIV      = 4;
    localparam int unsigned DEBOUNCE_CNT  = 8;
    localparam int unsigned REPEAT_DELAY  = 40;
    localparam int unsigned REPEAT_PERIOD = 20;
    localparam int          BUDGET        = 400;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    // key_down[col*4 + row] = key physically pressed
    logic [15:0] key_down = '0;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          pulse_cnt = 0;
    logic [3:0]  exp_q[$];
    int          pulse_cyc_q[$];
    logic [15:0] lock_sr   = '0;
    logic        prev_kv   = 1'b0;
    logic [3:0]  prev_code = 4'h0;
    logic [3:0]  mon_exp;

    keypad_scan_debounce #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_out   (col_out),
        .row_in    (row_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && key_down[c*4 + r]) row_in[r] = 1'b0;
            end
        end
    end

    // Strobe monitor: pops the scoreboard and checks strobe/code invariants
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_kv   = 1'b0;
            prev_code = 4'h0;
        end else begin
            if (key_valid) begin
                pulse_cnt++;
                pulse_cyc_q.push_back(cyc);
                lock_sr = {lock_sr[11:0], key_code};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: key_code %h at cycle %0d, none required", key_code, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (key_code !== mon_exp) begin
                        errors++;
                        $display("FAIL pulse_code: got %h required %h", key_code, mon_exp);
                    end
                end
                checks++;
                if (prev_kv) begin
                    errors++;
                    $display("FAIL back_to_back: key_valid high on consecutive cycles at %0d", cyc);
                end
            end
            if (key_code !== prev_code) begin
                checks++;
                if (!key_valid) begin
                    errors++;
                    $display("FAIL code_change: key_code %h -> %h without key_valid", prev_code, key_code);
                end
            end
            prev_kv   = key_valid;
            prev_code = key_code;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: col %b code %h valid %b held %b required 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(6);
        checks++;
        if (col_out !== 4'b1101) begin
            errors++;
            $display("FAIL scan_advance: col %b required 1101", col_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan: col %b code %h valid %b held %b required 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_clean_press();
        int base;
        int n;
        base = pulse_cnt;
        exp_q.push_back(4'h5);
        key_down[1*4 + 1] = 1'b1;
        n = 0;
        while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
        checks++;
        if (pulse_cnt !== base + 1) begin
            errors++;
            $display("FAIL clean_pulse: pulses %0d required %0d", pulse_cnt - base, 1);
        end
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'h5) begin
            errors++;
            $display("FAIL clean_held: held %b code %h required 1 5", key_held, key_code);
        end
        step(20);
        checks++;
        if (pulse_cnt !== base + 1) begin
            errors++;
            $display("FAIL clean_single: pulses %0d required 1", pulse_cnt - base);
        end
        key_down = '0;
        n = 0;
        while (key_held === 1'b1 && n < BUDGET) begin step(1); n++; end
        checks++;
        if (key_held !== 1'b0 || n < int'(DEBOUNCE_CNT) || n > int'(DEBOUNCE_CNT) + 4) begin
            errors++;
            $display("FAIL clean_release: held %b after %0d cycles required 0 within %0d..%0d",
                     key_held, n, DEBOUNCE_CNT, DEBOUNCE_CNT + 4);
        end
        step(30);
        checks++;
        if (pulse_cnt !== base + 1) begin
            errors++;
            $display("FAIL clean_no_release_pulse: pulses %0d required 1", pulse_cnt - base);
        end
    endtask

    task automatic test_bounce();
        int base;
        int n;
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            key_down[3*4 + 2] = ~key_down[3*4 + 2];
            step(3);
        end
        checks++;
        if (pulse_cnt !== base) begin
            errors++;
            $display("FAIL bounce_quiet: pulses %0d required 0", pulse_cnt - base);
        end
        exp_q.push_back(4'hC);
        key_down[3*4 + 2] = 1'b1;
        n = 0;
        while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
        checks++;
        if (pulse_cnt !== base + 1 || key_code !== 4'hC) begin
            errors++;
            $display("FAIL bounce_pulse: pulses %0d code %h required 1 C", pulse_cnt - base, key_code);
        end
        key_down = '0;
        n = 0;
        while (key_held === 1'b1 && n < BUDGET) begin step(1); n++; end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: held %b required 0", key_held);
        end
    endtask

    task automatic test_sequence();
        int         bits[4]  = '{0, 4, 8, 1};
        logic [3:0] codes[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        int base;
        int n;
        lock_sr = '0;
        for (int k = 0; k < 4; k++) begin
            base = pulse_cnt;
            exp_q.push_back(codes[k]);
            key_down[bits[k]] = 1'b1;
            n = 0;
            while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
            checks++;
            if (pulse_cnt !== base + 1) begin
                errors++;
                $display("FAIL seq_pulse_%0d: pulses %0d required 1", k, pulse_cnt - base);
            end
            key_down = '0;
            n = 0;
            while (key_held === 1'b1 && n < BUDGET) begin step(1); n++; end
            checks++;
            if (key_held !== 1'b0) begin
                errors++;
                $display("FAIL seq_release_%0d: held %b required 0", k, key_held);
            end
        end
        checks++;
        if (lock_sr !== 16'h1234) begin
            errors++;
            $display("FAIL seq_lock: got %h required 1234", lock_sr);
        end
    endtask

    task automatic test_ghost();
        int         base;
        logic [3:0] seen;
        logic       bad;
        base = pulse_cnt;
        seen = 4'b0000;
        bad  = 1'b0;
        key_down[2*4 + 0] = 1'b1;
        key_down[2*4 + 1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            case (col_out)
                4'b1110: seen[0] = 1'b1;
                4'b1101: seen[1] = 1'b1;
                4'b1011: seen[2] = 1'b1;
                4'b0111: seen[3] = 1'b1;
                default: bad = 1'b1;
            endcase
        end
        checks++;
        if (pulse_cnt !== base || key_held !== 1'b0) begin
            errors++;
            $display("FAIL ghost_quiet: pulses %0d held %b required 0 0", pulse_cnt - base, key_held);
        end
        checks++;
        if (seen !== 4'b1111 || bad !== 1'b0) begin
            errors++;
            $display("FAIL ghost_scan: columns seen %b non-onehot %b required 1111 0", seen, bad);
        end
        key_down = '0;
        step(10);
    endtask

    task automatic test_repeat();
`ifdef KEYPAD_REPEAT_EN
        int exp_off[$] = '{0, 40, 60, 80, 100};
`else
        int exp_off[$] = '{0};
`endif
        int base;
        int n;
        int c0;
        base = pulse_cnt;
        pulse_cyc_q.delete();
        for (int k = 0; k < exp_off.size(); k++) exp_q.push_back(4'hD);
        key_down[3*4 + 3] = 1'b1;
        n = 0;
        while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
        checks++;
        if (pulse_cnt == base) begin
            errors++;
            $display("FAIL repeat_accept: pulses 0 required >= 1");
            c0 = cyc;
        end else begin
            c0 = pulse_cyc_q[0];
        end
        while (cyc < c0 + 101) step(1);
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL repeat_held: held %b required 1", key_held);
        end
        key_down = '0;
        n = 0;
        while (key_held === 1'b1 && n < BUDGET) begin step(1); n++; end
        step(10);
        checks++;
        if (pulse_cyc_q.size() !== exp_off.size()) begin
            errors++;
            $display("FAIL repeat_count: pulses %0d required %0d", pulse_cyc_q.size(), exp_off.size());
        end else begin
            for (int k = 0; k < exp_off.size(); k++) begin
                checks++;
                if (pulse_cyc_q[k] - c0 !== exp_off[k]) begin
                    errors++;
                    $display("FAIL repeat_time_%0d: offset %0d required %0d", k, pulse_cyc_q[k] - c0, exp_off[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int base;
        int n;
        base = pulse_cnt;
        exp_q.push_back(4'h7);
        key_down[0*4 + 2] = 1'b1;
        n = 0;
        while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
        checks++;
        if (pulse_cnt !== base + 1 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL rmp_first: pulses %0d held %b required 1 1", pulse_cnt - base, key_held);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL rmp_reset: col %b code %h valid %b held %b required 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        end
        step(3);
        rst_n = 1'b1;
        base = pulse_cnt;
        exp_q.push_back(4'h7);
        n = 0;
        while (pulse_cnt == base && n < BUDGET) begin step(1); n++; end
        checks++;
        if (pulse_cnt !== base + 1 || key_code !== 4'h7) begin
            errors++;
            $display("FAIL rmp_redebounce: pulses %0d code %h required 1 7", pulse_cnt - base, key_code);
        end
        key_down = '0;
        n = 0;
        while (key_held === 1'b1 && n < BUDGET) begin step(1); n++; end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL rmp_release: held %b required 0", key_held);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_ghost();
        test_repeat();
        test_reset_mid_press();
        step(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
